// File: rtl/mc_fifo_pkg.sv
// mc_fifo_pkg: shared helpers for the multi-channel FIFO.
//   clog2_min1  - ceil(log2(n)), never below 1 (index widths)
//   ptr_width   - pointer width for a channel of 2**log_depth entries (one wrap bit)
//   ptr_full    - wptr-rptr difference that marks a full channel (MSB only)
//   ptr_empty   - wptr-rptr difference that marks an empty channel
// Users derive their own pointer/usage type as logic [ptr_width(LOG_DEPTH)-1:0].
package mc_fifo_pkg;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned log_depth);
        return log_depth + 1;
    endfunction

    function automatic int unsigned ptr_full(input int unsigned log_depth);
        return 1 << log_depth;
    endfunction

    function automatic int unsigned ptr_empty(input int unsigned log_depth);
        return (log_depth > 0) ? 0 : 0;
    endfunction

endpackage

// File: rtl/mc_fifo_chan_ctrl.sv
// mc_fifo_chan_ctrl: pointer bookkeeping for one channel of mc_fifo.
// Optional feature: MC_FIFO_FALL_THROUGH_EN (push to an empty channel is visible same cycle).
//   clk_i, rst_ni   clock, async active-low reset
//   flush_i         clear both pointers at the next edge (overrides pop)
//   push_i          a push to this channel fires this cycle
//   pop_ready_i     consumer accepts the head
//   push_ready_o    channel can accept (not full, not flushing)
//   pop_valid_o     channel has a head entry
//   wr_o            storage write enable for this channel
//   fwd_o           (fall-through only) head comes from the push port this cycle
//   wptr_o, rptr_o  storage offsets within the channel
//   usage_o         fill level 0..2**LOG_DEPTH
module mc_fifo_chan_ctrl
    import mc_fifo_pkg::*;
#(
    parameter int unsigned LOG_DEPTH = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  logic                 pop_ready_i,
    output logic                 push_ready_o,
    output logic                 pop_valid_o,
    output logic                 wr_o,
`ifdef MC_FIFO_FALL_THROUGH_EN
    output logic                 fwd_o,
`endif
    output logic [LOG_DEPTH-1:0] wptr_o,
    output logic [LOG_DEPTH-1:0] rptr_o,
    output logic [LOG_DEPTH:0]   usage_o
);

    localparam int unsigned PtrW = ptr_width(LOG_DEPTH);
    typedef logic [PtrW-1:0] ptr_t;

    localparam ptr_t FullDiff  = ptr_t'(ptr_full(LOG_DEPTH));
    localparam ptr_t EmptyDiff = ptr_t'(ptr_empty(LOG_DEPTH));

    ptr_t wptr_q, wptr_d;
    ptr_t rptr_q, rptr_d;
    ptr_t diff;
    logic empty;
    logic full;
    logic rd_adv;

    assign diff  = wptr_q - rptr_q;
    assign empty = (diff == EmptyDiff);
    // Full when pointers differ only in the wrap bit.
    assign full  = ((wptr_q ^ rptr_q) == FullDiff);

    // Independent of pop_ready_i: a full channel stays not-ready even while popped.
    assign push_ready_o = !full && !flush_i;

`ifdef MC_FIFO_FALL_THROUGH_EN
    assign fwd_o       = empty && push_i;
    assign pop_valid_o = !empty || push_i;
    // A forwarded word taken in the same cycle never touches storage.
    assign wr_o        = push_i && !(fwd_o && pop_ready_i);
    assign rd_adv      = !empty && pop_ready_i;
`else
    assign pop_valid_o = !empty;
    assign wr_o        = push_i;
    assign rd_adv      = pop_valid_o && pop_ready_i;
`endif

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            wptr_d = wptr_q + ptr_t'(wr_o);
            rptr_d = rptr_q + ptr_t'(rd_adv);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    assign wptr_o  = wptr_q[LOG_DEPTH-1:0];
    assign rptr_o  = rptr_q[LOG_DEPTH-1:0];
    assign usage_o = diff;

endmodule

// File: rtl/mc_fifo.sv
// mc_fifo: single-clock multi-channel FIFO. One storage array is split into NumChan
// circular queues of 2**LOG_DEPTH entries; one tagged push port, one valid/ready pop
// port per channel.
// Optional feature: MC_FIFO_FALL_THROUGH_EN (same-cycle delivery into an empty channel).
//   clk_i, rst_ni   clock, async active-low reset
//   flush_i         per-channel synchronous clear
//   push_data_i     write payload
//   push_chan_i     destination channel
//   push_valid_i    push request
//   push_ready_o    selected channel can accept (0 for out-of-range channel)
//   pop_data_o      head entry per channel
//   pop_valid_o     per-channel non-empty
//   pop_ready_i     per-channel consumer accept
//   usage_o         per-channel fill level
module mc_fifo
    import mc_fifo_pkg::*;
#(
    parameter type         T            = logic,
    parameter int unsigned NumChan      = 4,
    parameter int unsigned LOG_DEPTH    = 3,
    parameter int unsigned ChanIdxWidth = clog2_min1(NumChan)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NumChan-1:0]              flush_i,
    input  T                                push_data_i,
    input  logic [ChanIdxWidth-1:0]         push_chan_i,
    input  logic                            push_valid_i,
    output logic                            push_ready_o,
    output T     [NumChan-1:0]              pop_data_o,
    output logic [NumChan-1:0]              pop_valid_o,
    input  logic [NumChan-1:0]              pop_ready_i,
    output logic [NumChan-1:0][LOG_DEPTH:0] usage_o
);

    localparam int unsigned Depth   = 1 << LOG_DEPTH;
    localparam int unsigned Entries = NumChan * Depth;
    localparam int unsigned AddrW   = clog2_min1(Entries);

    T mem_q [Entries];

    logic [NumChan-1:0]                push_sel;
    logic [NumChan-1:0]                chan_ready;
    logic [NumChan-1:0]                push_fire;
    logic [NumChan-1:0]                wr_vec;
    logic [NumChan-1:0][LOG_DEPTH-1:0] wptr_lo;
    logic [NumChan-1:0][LOG_DEPTH-1:0] rptr_lo;
    logic                              wr_en;
    logic [AddrW-1:0]                  wr_addr;
`ifdef MC_FIFO_FALL_THROUGH_EN
    logic [NumChan-1:0]                fwd;
`endif

    // One-hot decode; an out-of-range channel selects nothing and so is never ready.
    always_comb begin
        push_sel = '0;
        for (int c = 0; c < NumChan; c++) begin
            push_sel[c] = (push_chan_i == ChanIdxWidth'(c));
        end
    end

    assign push_ready_o = |(push_sel & chan_ready);
    assign push_fire    = push_sel & chan_ready & {NumChan{push_valid_i}};

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        mc_fifo_chan_ctrl #(
            .LOG_DEPTH (LOG_DEPTH)
        ) u_ctrl (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .flush_i      (flush_i[c]),
            .push_i       (push_fire[c]),
            .pop_ready_i  (pop_ready_i[c]),
            .push_ready_o (chan_ready[c]),
            .pop_valid_o  (pop_valid_o[c]),
            .wr_o         (wr_vec[c]),
`ifdef MC_FIFO_FALL_THROUGH_EN
            .fwd_o        (fwd[c]),
`endif
            .wptr_o       (wptr_lo[c]),
            .rptr_o       (rptr_lo[c]),
            .usage_o      (usage_o[c])
        );

`ifdef MC_FIFO_FALL_THROUGH_EN
        assign pop_data_o[c] = fwd[c] ? push_data_i
                                      : mem_q[AddrW'(c * Depth) + AddrW'(rptr_lo[c])];
`else
        assign pop_data_o[c] = mem_q[AddrW'(c * Depth) + AddrW'(rptr_lo[c])];
`endif
    end

    // At most one bit of wr_vec is set: pushes are serialised through one port.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        for (int c = 0; c < NumChan; c++) begin
            if (wr_vec[c]) begin
                wr_en   = 1'b1;
                wr_addr = AddrW'(c * Depth) + AddrW'(wptr_lo[c]);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Entries; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= push_data_i;
        end
    end

endmodule

// File: tb/tb_mc_fifo.sv
// tb_mc_fifo: randomized and directed checks of mc_fifo against a queue-based model.
module tb_mc_fifo;

    localparam int NC  = 4;
    localparam int DEP = 8;

    typedef logic [7:0] data_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NC-1:0]    flush;
    data_t            pd;
    logic [1:0]       pc;
    logic             pv;
    logic             prdy;
    data_t [NC-1:0]   pop_data;
    logic [NC-1:0]    pop_valid;
    logic [NC-1:0]    pop_ready;
    logic [NC-1:0][3:0] usage;

    mc_fifo #(
        .T         (data_t),
        .NumChan   (NC),
        .LOG_DEPTH (3)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .push_data_i  (pd),
        .push_chan_i  (pc),
        .push_valid_i (pv),
        .push_ready_o (prdy),
        .pop_data_o   (pop_data),
        .pop_valid_o  (pop_valid),
        .pop_ready_i  (pop_ready),
        .usage_o      (usage)
    );

    always #5 clk = ~clk;

`ifdef MC_FIFO_FALL_THROUGH_EN
    localparam bit FT = 1'b1;
`else
    localparam bit FT = 1'b0;
`endif

    // Model: one queue per channel holding the words not yet popped.
    data_t q [NC][$];
    int    n_chk = 0;
    int    n_pass = 0;
    bit    chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic bit m_ready(input int ch);
        return (q[ch].size() < DEP) && !flush[ch];
    endfunction

    function automatic bit m_fire(input int ch);
        return pv && (int'(pc) == ch) && m_ready(ch);
    endfunction

    function automatic bit m_valid(input int ch);
        return (q[ch].size() > 0) || (FT && m_fire(ch));
    endfunction

    function automatic data_t m_data(input int ch);
        return (q[ch].size() > 0) ? q[ch][0] : pd;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NC; c++) q[c].delete();
        end else begin
            bit fire [NC];
            for (int c = 0; c < NC; c++) fire[c] = m_fire(c);
            for (int c = 0; c < NC; c++) begin
                if (flush[c]) begin
                    q[c].delete();
                end else if (!(FT && fire[c] && q[c].size() == 0 && pop_ready[c])) begin
                    if (q[c].size() > 0 && pop_ready[c]) void'(q[c].pop_front());
                    if (fire[c]) q[c].push_back(pd);
                end
            end
        end
    end

    // Compare every cycle, mid-period.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("push_ready", 32'(prdy), 32'(m_ready(int'(pc))));
            for (int c = 0; c < NC; c++) begin
                chk($sformatf("pop_valid[%0d]", c), 32'(pop_valid[c]), 32'(m_valid(c)));
                chk($sformatf("usage[%0d]", c), 32'(usage[c]), 32'(q[c].size()));
                if (m_valid(c))
                    chk($sformatf("pop_data[%0d]", c), 32'(pop_data[c]), 32'(m_data(c)));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input int d);
        pv = 1'b1;
        pc = 2'(ch);
        pd = 8'(d);
        tick();
        pv = 1'b0;
    endtask

    initial begin
        flush     = '0;
        pd        = '0;
        pc        = '0;
        pv        = 1'b0;
        pop_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset / idle
        for (int ch = 0; ch < NC; ch++) begin
            pc = 2'(ch);
            #1;
            chk("idle_ready", 32'(prdy), 32'd1);
        end
        chk("idle_usage", 32'(usage), 32'd0);
        chk("idle_valid", 32'(pop_valid), 32'd0);
        chk("idle_data", 32'(pop_data), 32'd0);
        tick();

        // Fill chan 2, check full, drain in order
        for (int i = 0; i < DEP; i++) push(2, 8'h20 + i);
        pc = 2'd2;
        #1;
        chk("ch2_usage_full", 32'(usage[2]), 32'd8);
        chk("ch2_ready_full", 32'(prdy), 32'd0);
        pc = 2'd0;
        #1;
        chk("ch0_ready", 32'(prdy), 32'd1);
        for (int i = 0; i < DEP; i++) begin
            pop_ready = 4'b0100;
            #1;
            chk("ch2_order", 32'(pop_data[2]), 32'(8'h20 + i));
            tick();
        end
        pop_ready = '0;

        // Chan 1 stalled full, chan 0 streams past it
        for (int i = 0; i < DEP; i++) push(1, 8'h10 + i);
        pop_ready = 4'b0001;
        for (int i = 0; i < DEP; i++) push(0, 8'h30 + i);
        tick();
        tick();
        chk("ch0_drained", 32'(usage[0]), 32'd0);
        chk("ch1_held", 32'(usage[1]), 32'd8);
        chk("ch1_head", 32'(pop_data[1]), 32'h10);
        pop_ready = '0;

        // Full chan 3: push and pop together, push rejected
        flush = 4'hf;
        tick();
        flush = '0;
        for (int i = 0; i < DEP; i++) push(3, 8'h40 + i);
        pv = 1'b1;
        pc = 2'd3;
        pd = 8'hee;
        pop_ready = 4'b1000;
        #1;
        chk("ch3_full_ready", 32'(prdy), 32'd0);
        tick();
        pv = 1'b0;
        pop_ready = '0;
        #1;
        chk("ch3_usage7", 32'(usage[3]), 32'd7);
        chk("ch3_head", 32'(pop_data[3]), 32'h41);

        // Flush with concurrent push and pop on chan 0
        flush = 4'hf;
        tick();
        flush = '0;
        for (int i = 0; i < 5; i++) push(0, 8'h50 + i);
        chk("ch0_usage5", 32'(usage[0]), 32'd5);
        flush = 4'b0001;
        pv = 1'b1;
        pc = 2'd0;
        pd = 8'h77;
        pop_ready = 4'b0001;
        #1;
        chk("flush_ready", 32'(prdy), 32'd0);
        tick();
        flush = '0;
        pv = 1'b0;
        pop_ready = '0;
        #1;
        chk("flush_usage", 32'(usage[0]), 32'd0);
        chk("flush_valid", 32'(pop_valid[0]), 32'd0);

        // Random interleaving with pointer wrap
        for (int n = 0; n < 400; n++) begin
            pv = 1'($urandom_range(0, 3) != 0);
            pc = 2'($urandom_range(0, NC - 1));
            pd = 8'($urandom);
            pop_ready = 4'($urandom);
            for (int c = 0; c < NC; c++) flush[c] = ($urandom_range(0, 47) == 0);
            tick();
        end
        pv = 1'b0;
        flush = '0;
        pop_ready = '0;

`ifdef MC_FIFO_FALL_THROUGH_EN
        flush = 4'hf;
        tick();
        flush = '0;
        pv = 1'b1;
        pc = 2'd1;
        pd = 8'ha5;
        pop_ready = 4'b0010;
        #1;
        chk("ft_valid", 32'(pop_valid[1]), 32'd1);
        chk("ft_data", 32'(pop_data[1]), 32'ha5);
        tick();
        pv = 1'b0;
        pop_ready = '0;
        #1;
        chk("ft_usage", 32'(usage[1]), 32'd0);
`endif

        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
